alarm_ctrl: RTL and testbench
=============================

Name: alarm_ctrl

Overview:
- Downstream consumer of the 12-hour clock block (hourclock).
- Holds a programmable alarm time and compares it against the clock's BCD hour/min/sec/pm outputs.
- Runs a ring/snooze/stop state machine timed by the same 1 Hz enable tick that advances the clock.
- Drives the buzzer and alarm status toward the display/UI layer.

Parameters:
RING_SECS, 60, number of ena ticks the alarm rings before auto-stop
SNOOZE_SECS, 300, number of ena ticks spent in snooze before re-ringing
SNOOZE_MAX, 3, maximum snoozes per alarm event; further snooze presses are ignored

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
ena  input  1  one-second tick, the same signal that enables hourclock
hour  input  8  BCD hour 01..12 from hourclock
min  input  8  BCD minute 00..59 from hourclock
sec  input  8  BCD second 00..59 from hourclock
pm  input  1  PM flag from hourclock
arm  input  1  level; alarm enabled when 1
set_we  input  1  one-cycle strobe; loads set_hour/set_min/set_pm
set_hour  input  8  BCD alarm hour
set_min  input  8  BCD alarm minute
set_pm  input  1  alarm PM flag
snooze  input  1  one-cycle pulse
stop  input  1  one-cycle pulse
ringing  output  1  1 in RINGING
snoozing  output  1  1 in SNOOZE
buzz  output  1  buzzer drive
snooze_cnt  output  2  snoozes used in the current event
set_err  output  1  one-cycle pulse on a rejected write
al_hour  output  8  stored alarm hour
al_min  output  8  stored alarm minute
al_pm  output  1  stored alarm PM flag

Behaviour:
- Reset (async, immediate): state IDLE; al_hour=8'h12, al_min=8'h00, al_pm=0; ringing=snoozing=buzz=set_err=0; snooze_cnt=0; tick counter=0; prev_match=1.
- All outputs are registered.
- Write: on set_we, the write is valid iff set_hour is BCD 01..12 and set_min is BCD 00..59 (each nibble ≤9, upper minute nibble ≤5).
  - Valid write: al_* updates the next cycle.
  - Invalid write: al_* unchanged, set_err=1 for exactly one cycle.
  - A write never alters the current state.
- match = (hour==al_hour)&&(min==al_min)&&(sec==8'h00)&&(pm==al_pm), evaluated combinationally each cycle.
- prev_match <= match every cycle. trigger = match & ~prev_match.
  - A paused clock (ena=0) holding 00 seconds triggers only once.
  - Writing an alarm equal to the current hh:mm:00 triggers the next cycle.
- States:
  - IDLE: if arm & trigger -> RINGING; counter=0, snooze_cnt=0.
  - RINGING: each ena tick increments the counter and toggles buzz. When the counter reaches RING_SECS-1 on an ena tick -> IDLE.
  - SNOOZE: each ena tick increments the counter. When the counter reaches SNOOZE_SECS-1 on an ena tick -> RINGING, counter=0.
- Priority, evaluated every cycle: arm=0 -> IDLE (from any state) > stop -> IDLE > snooze > timeout.
- snooze in RINGING with snooze_cnt<SNOOZE_MAX -> SNOOZE; counter=0, snooze_cnt+1, buzz=0.
- snooze in RINGING with snooze_cnt==SNOOZE_MAX is ignored; snooze outside RINGING is ignored.
- Simultaneous stop and snooze: stop wins. Simultaneous timeout tick and snooze: snooze wins.
- buzz is 0 outside RINGING and is cleared on every entry to IDLE/SNOOZE. It is set to 1 on entry to RINGING.
- trigger while RINGING/SNOOZE is ignored.
- Counters are sized $clog2(max(RING_SECS,SNOOZE_SECS)) bits. They saturate-free wrap never occurs because the terminal compare precedes overflow.
- Reset mid-ring returns to IDLE immediately. prev_match=1 after reset, so no spurious trigger at 12:00:00 AM.

Optional Feature:
- Macro ALARM_SNOOZE_EN.
- Defined: snooze behaviour as above.
- Undefined: SNOOZE state is not built; the snooze input is ignored; snoozing and snooze_cnt are tied 0; RINGING exits only by stop, arm=0, timeout or reset.

Decomposition:
- Shared package clock_pkg: state enum (IDLE, RINGING, SNOOZE), BCD constants (BCD_12=8'h12, BCD_59=8'h59, BCD_00), hour/min BCD width localparam.
- Sub-module bcd_time_valid: combinational validity check of hour/min. It is reusable by a future time-set block for hourclock.

Test Plan:
(Bench params RING_SECS=5, SNOOZE_SECS=3, SNOOZE_MAX=2, with hourclock instantiated, ena=1.)
- Reset, arm=1, alarm 12:00 AM -> no ring at time 0. Write 12:00:03 target? No: write 12:01 AM, run -> ringing rises one cycle after clock shows 12:01:00 AM; buzz toggles; returns IDLE after 5 ticks.
- Write set_hour=8'h13 or set_min=8'h60 -> set_err one cycle, al_hour/al_min unchanged; write 8'h00 hour -> rejected.
- Ring, snooze -> snoozing=1 for 3 ticks, ring again, snooze_cnt=1; second snooze -> cnt=2; third snooze ignored; timeout -> IDLE, cnt cleared on next trigger.
- Ring with stop and snooze asserted in the same cycle -> IDLE, snooze_cnt unchanged; arm=0 during SNOOZE -> IDLE at once.
- Pause clock (ena=0) for 400 ns while at alarm hh:mm:00 -> exactly one trigger; async reset mid-ring -> all outputs 0 immediately, al_* = 12:00 AM.
- Rebuild without ALARM_SNOOZE_EN -> snooze pulse during RINGING has no effect; snoozing/snooze_cnt stay 0.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and BCD constants for the 12-hour clock family (hourclock, alarm_ctrl).
// No logic lives here; only the state enum and width/constant definitions.
package clock_pkg;

    localparam int BCD_W = 8;

    localparam logic [BCD_W-1:0] BCD_00 = 8'h00;
    localparam logic [BCD_W-1:0] BCD_12 = 8'h12;
    localparam logic [BCD_W-1:0] BCD_59 = 8'h59;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } alarm_state_t;

endpackage

// File: rtl/bcd_time_valid.sv
// Combinational check that a BCD hour is 01..12 and a BCD minute is 00..59.
// Zero latency; shared with any block that accepts a user-entered time.
module bcd_time_valid
    import clock_pkg::*;
(
    input  logic [BCD_W-1:0] hour_i,
    input  logic [BCD_W-1:0] min_i,
    output logic             valid_o
);

    logic hour_ok;
    logic min_ok;

    // The upper-range compares also bound the tens nibble, so only the units nibble needs its own check.
    assign hour_ok = (hour_i[3:0] <= 4'd9) && (hour_i != BCD_00) && (hour_i <= BCD_12);
    assign min_ok  = (min_i[3:0] <= 4'd9) && (min_i <= BCD_59);
    assign valid_o = hour_ok && min_ok;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm time register plus ring/snooze/stop FSM timed by the hourclock 1 Hz ena tick; all outputs registered.
// Snooze (SNOOZE state, snoozing, snooze_cnt) is only built when ALARM_SNOOZE_EN is defined.
module alarm_ctrl
    import clock_pkg::*;
#(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int SNOOZE_MAX  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ena,
    input  logic [BCD_W-1:0] hour,
    input  logic [BCD_W-1:0] min,
    input  logic [BCD_W-1:0] sec,
    input  logic             pm,
    input  logic             arm,
    input  logic             set_we,
    input  logic [BCD_W-1:0] set_hour,
    input  logic [BCD_W-1:0] set_min,
    input  logic             set_pm,
    input  logic             snooze,
    input  logic             stop,
    output logic             ringing,
    output logic             snoozing,
    output logic             buzz,
    output logic [1:0]       snooze_cnt,
    output logic             set_err,
    output logic [BCD_W-1:0] al_hour,
    output logic [BCD_W-1:0] al_min,
    output logic             al_pm
);

    localparam int MAX_SECS = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
    localparam int CNT_W    = (MAX_SECS > 1) ? $clog2(MAX_SECS) : 1;
    localparam logic [CNT_W-1:0] RING_LAST = CNT_W'(RING_SECS - 1);

    alarm_state_t     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             prev_match_q;
    logic             ringing_q;
    logic             buzz_q;
    logic             set_err_q;
    logic [BCD_W-1:0] al_hour_q;
    logic [BCD_W-1:0] al_min_q;
    logic             al_pm_q;

    logic match;
    logic trigger;
    logic wr_valid;

    bcd_time_valid u_wr_chk (
        .hour_i  (set_hour),
        .min_i   (set_min),
        .valid_o (wr_valid)
    );

    // Edge-detect the match so a paused clock sitting on hh:mm:00 rings only once.
    assign match   = (hour == al_hour_q) && (min == al_min_q) && (sec == BCD_00) && (pm == al_pm_q);
    assign trigger = match & ~prev_match_q;

`ifdef ALARM_SNOOZE_EN
    localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_SECS - 1);
    logic       snoozing_q;
    logic [1:0] snooze_cnt_q;
`else
    logic unused_snooze;
    assign unused_snooze = snooze & (SNOOZE_MAX > 0);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            prev_match_q <= 1'b1;
            ringing_q    <= 1'b0;
            buzz_q       <= 1'b0;
            set_err_q    <= 1'b0;
            al_hour_q    <= BCD_12;
            al_min_q     <= BCD_00;
            al_pm_q      <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            snoozing_q   <= 1'b0;
            snooze_cnt_q <= 2'd0;
`endif
        end else begin
            prev_match_q <= match;
            set_err_q    <= set_we & ~wr_valid;
            if (set_we && wr_valid) begin
                al_hour_q <= set_hour;
                al_min_q  <= set_min;
                al_pm_q   <= set_pm;
            end

            if (!arm) begin
                state_q    <= IDLE;
                ringing_q  <= 1'b0;
                buzz_q     <= 1'b0;
`ifdef ALARM_SNOOZE_EN
                snoozing_q <= 1'b0;
`endif
            end else begin
                case (state_q)
                    IDLE: begin
                        if (trigger) begin
                            state_q      <= RINGING;
                            ringing_q    <= 1'b1;
                            buzz_q       <= 1'b1;
                            cnt_q        <= '0;
`ifdef ALARM_SNOOZE_EN
                            snooze_cnt_q <= 2'd0;
`endif
                        end
                    end
                    RINGING: begin
                        if (stop) begin
                            state_q   <= IDLE;
                            ringing_q <= 1'b0;
                            buzz_q    <= 1'b0;
`ifdef ALARM_SNOOZE_EN
                        end else if (snooze && (snooze_cnt_q < 2'(SNOOZE_MAX))) begin
                            state_q      <= SNOOZE;
                            ringing_q    <= 1'b0;
                            snoozing_q   <= 1'b1;
                            buzz_q       <= 1'b0;
                            cnt_q        <= '0;
                            snooze_cnt_q <= snooze_cnt_q + 2'd1;
`endif
                        end else if (ena) begin
                            if (cnt_q == RING_LAST) begin
                                state_q   <= IDLE;
                                ringing_q <= 1'b0;
                                buzz_q    <= 1'b0;
                            end else begin
                                cnt_q  <= cnt_q + 1'b1;
                                buzz_q <= ~buzz_q;
                            end
                        end
                    end
`ifdef ALARM_SNOOZE_EN
                    SNOOZE: begin
                        if (stop) begin
                            state_q    <= IDLE;
                            snoozing_q <= 1'b0;
                            buzz_q     <= 1'b0;
                        end else if (ena) begin
                            if (cnt_q == SNOOZE_LAST) begin
                                state_q    <= RINGING;
                                snoozing_q <= 1'b0;
                                ringing_q  <= 1'b1;
                                buzz_q     <= 1'b1;
                                cnt_q      <= '0;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                    end
`endif
                    default: begin
                        state_q   <= IDLE;
                        ringing_q <= 1'b0;
                        buzz_q    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ringing = ringing_q;
    assign buzz    = buzz_q;
    assign set_err = set_err_q;
    assign al_hour = al_hour_q;
    assign al_min  = al_min_q;
    assign al_pm   = al_pm_q;
`ifdef ALARM_SNOOZE_EN
    assign snoozing   = snoozing_q;
    assign snooze_cnt = snooze_cnt_q;
`else
    assign snoozing   = 1'b0;
    assign snooze_cnt = 2'd0;
`endif

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl with RING_SECS=5, SNOOZE_SECS=3, SNOOZE_MAX=2; time inputs driven directly.
module tb_alarm_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       ena;
    logic [7:0] hour, min, sec;
    logic       pm, arm, set_we;
    logic [7:0] set_hour, set_min;
    logic       set_pm, snooze, stop;
    logic       ringing, snoozing, buzz, set_err, al_pm;
    logic [1:0] snooze_cnt;
    logic [7:0] al_hour, al_min;

    int checks = 0;
    int errors = 0;

    alarm_ctrl #(.RING_SECS(5), .SNOOZE_SECS(3), .SNOOZE_MAX(2)) dut (
        .clk(clk), .reset(reset), .ena(ena), .hour(hour), .min(min), .sec(sec), .pm(pm),
        .arm(arm), .set_we(set_we), .set_hour(set_hour), .set_min(set_min), .set_pm(set_pm),
        .snooze(snooze), .stop(stop), .ringing(ringing), .snoozing(snoozing), .buzz(buzz),
        .snooze_cnt(snooze_cnt), .set_err(set_err), .al_hour(al_hour), .al_min(al_min), .al_pm(al_pm)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] h;
        logic [7:0] m;
        logic       p;
        logic       err;
        logic [7:0] eh;
        logic [7:0] em;
        logic       ep;
    } wr_vec_t;

    wr_vec_t vecs[7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic ring_at(input logic [7:0] h, input logic [7:0] m, input logic p);
        hour = h; min = m; pm = p; sec = 8'h59;
        step();
        sec = 8'h00;
        step();
        sec = 8'h01;
    endtask

    int rises;
    logic prev_r;

    initial begin
        vecs[0] = '{8'h13, 8'h00, 1'b0, 1'b1, 8'h12, 8'h00, 1'b0};
        vecs[1] = '{8'h12, 8'h60, 1'b0, 1'b1, 8'h12, 8'h00, 1'b0};
        vecs[2] = '{8'h00, 8'h30, 1'b0, 1'b1, 8'h12, 8'h00, 1'b0};
        vecs[3] = '{8'h0A, 8'h00, 1'b0, 1'b1, 8'h12, 8'h00, 1'b0};
        vecs[4] = '{8'h11, 8'h5A, 1'b1, 1'b1, 8'h12, 8'h00, 1'b0};
        vecs[5] = '{8'h01, 8'h59, 1'b1, 1'b0, 8'h01, 8'h59, 1'b1};
        vecs[6] = '{8'h12, 8'h01, 1'b0, 1'b0, 8'h12, 8'h01, 1'b0};

        reset = 1'b1; ena = 1'b1; arm = 1'b1;
        hour = 8'h12; min = 8'h00; sec = 8'h00; pm = 1'b0;
        set_we = 1'b0; set_hour = 8'h00; set_min = 8'h00; set_pm = 1'b0;
        snooze = 1'b0; stop = 1'b0;
        #1;
        check("rst_ringing", ringing, 0);
        check("rst_buzz", buzz, 0);
        check("rst_set_err", set_err, 0);
        check("rst_snooze_cnt", snooze_cnt, 0);
        check("rst_al_hour", al_hour, 8'h12);
        check("rst_al_min", al_min, 8'h00);
        check("rst_al_pm", al_pm, 0);
        step(); step();
        reset = 1'b0;
        step(); step(); step();
        check("no_ring_at_reset_time", ringing, 0);

        for (int i = 0; i < 7; i++) begin
            set_we = 1'b1; set_hour = vecs[i].h; set_min = vecs[i].m; set_pm = vecs[i].p;
            step();
            set_we = 1'b0;
            check($sformatf("wr%0d_err", i), set_err, vecs[i].err);
            check($sformatf("wr%0d_hour", i), al_hour, vecs[i].eh);
            check($sformatf("wr%0d_min", i), al_min, vecs[i].em);
            check($sformatf("wr%0d_pm", i), al_pm, vecs[i].ep);
            step();
            check($sformatf("wr%0d_err_drop", i), set_err, 0);
            check($sformatf("wr%0d_noring", i), ringing, 0);
        end

        // Ring at 12:01 AM and let it time out after five ticks.
        ring_at(8'h12, 8'h01, 1'b0);
        check("ring_rise", ringing, 1);
        check("ring_buzz_on", buzz, 1);
        set_we = 1'b1; set_hour = 8'h12; set_min = 8'h01; set_pm = 1'b0;
        step();
        set_we = 1'b0;
        check("ring_write_keeps_state", ringing, 1);
        check("ring_buzz_t1", buzz, 0);
        step(); step(); step();
        check("ring_t4", ringing, 1);
        check("ring_buzz_t4", buzz, 1);
        step();
        check("ring_timeout", ringing, 0);
        check("ring_timeout_buzz", buzz, 0);

        // Stop and snooze together: stop wins.
        ring_at(8'h12, 8'h01, 1'b0);
        stop = 1'b1; snooze = 1'b1;
        step();
        stop = 1'b0; snooze = 1'b0;
        check("stopsnz_ringing", ringing, 0);
        check("stopsnz_snoozing", snoozing, 0);
        check("stopsnz_cnt", snooze_cnt, 0);
        check("stopsnz_buzz", buzz, 0);

`ifdef ALARM_SNOOZE_EN
        ring_at(8'h12, 8'h01, 1'b0);
        snooze = 1'b1; step(); snooze = 1'b0;
        check("snz1_snoozing", snoozing, 1);
        check("snz1_ringing", ringing, 0);
        check("snz1_buzz", buzz, 0);
        check("snz1_cnt", snooze_cnt, 1);
        step(); step();
        check("snz1_hold", snoozing, 1);
        step();
        check("snz1_rering", ringing, 1);
        check("snz1_rering_buzz", buzz, 1);
        snooze = 1'b1; step(); snooze = 1'b0;
        check("snz2_cnt", snooze_cnt, 2);
        check("snz2_snoozing", snoozing, 1);
        step(); step(); step();
        check("snz2_rering", ringing, 1);
        snooze = 1'b1; step(); snooze = 1'b0;
        check("snz3_ignored_ring", ringing, 1);
        check("snz3_ignored_snoozing", snoozing, 0);
        check("snz3_cnt", snooze_cnt, 2);
        step(); step(); step();
        check("snz3_t4", ringing, 1);
        step();
        check("snz3_timeout", ringing, 0);
        check("snz3_cnt_kept", snooze_cnt, 2);
        ring_at(8'h12, 8'h01, 1'b0);
        check("retrig_cnt_clr", snooze_cnt, 0);
        snooze = 1'b1; step(); snooze = 1'b0;
        check("arm_snz_entry", snoozing, 1);
        arm = 1'b0; step(); arm = 1'b1;
        check("arm0_snoozing", snoozing, 0);
        check("arm0_ringing", ringing, 0);
`else
        ring_at(8'h12, 8'h01, 1'b0);
        step();
        snooze = 1'b1; step(); snooze = 1'b0;
        check("nosnz_ringing", ringing, 1);
        check("nosnz_snoozing", snoozing, 0);
        check("nosnz_cnt", snooze_cnt, 0);
        check("nosnz_buzz", buzz, 1);
        arm = 1'b0; step(); arm = 1'b1;
        check("arm0_ringing", ringing, 0);
        check("arm0_buzz", buzz, 0);
`endif

        // Paused clock parked on the alarm time must trigger exactly once.
        set_we = 1'b1; set_hour = 8'h06; set_min = 8'h30; set_pm = 1'b1;
        step();
        set_we = 1'b0;
        ena = 1'b0;
        hour = 8'h06; min = 8'h30; sec = 8'h00; pm = 1'b1;
        rises = 0; prev_r = ringing;
        for (int i = 0; i < 40; i++) begin
            step();
            if (ringing && !prev_r) rises++;
            prev_r = ringing;
        end
        check("pause_rises", 8'(rises), 1);
        check("pause_ringing", ringing, 1);
        check("pause_buzz_held", buzz, 1);
        stop = 1'b1; step(); stop = 1'b0;
        check("pause_stop", ringing, 0);
        step(); step(); step(); step(); step();
        check("pause_no_retrigger", ringing, 0);
        ena = 1'b1;

        // Asynchronous reset in the middle of a ring.
        ring_at(8'h06, 8'h30, 1'b1);
        step();
        check("pre_reset_ringing", ringing, 1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_ringing", ringing, 0);
        check("arst_buzz", buzz, 0);
        check("arst_al_hour", al_hour, 8'h12);
        check("arst_al_min", al_min, 8'h00);
        check("arst_al_pm", al_pm, 0);
        hour = 8'h12; min = 8'h00; sec = 8'h00; pm = 1'b0;
        step(); step();
        reset = 1'b0;
        step(); step(); step();
        check("post_reset_no_ring", ringing, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
